// File: rtl/m_sram16_wbctrl_pkg.sv
// Shared definitions for the 16-bit SRAM Wishbone controller: FSM states,
// half-word select constants and the first-phase decode.
package m_sram16_wbctrl_pkg;

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_LO   = 5'b00010,
    S_TURN = 5'b00100,
    S_HI   = 5'b01000,
    S_ACK  = 5'b10000
  } state_t;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  localparam int unsigned CNT_W          = 3;
  localparam int unsigned MAX_WAITSTATES = 7;

  // Low half first when any low lane is selected; SEL==0 goes straight to ACK.
  function automatic state_t first_state(input logic [3:0] sel);
    if (|sel[1:0])      return S_LO;
    else if (|sel[3:2]) return S_HI;
    else                return S_ACK;
  endfunction

endpackage

// File: rtl/m_sram16_phasecnt.sv
// Wait-state counter for one half-word phase: counts 0..WAITSTATES while run
// is high and flags the terminal cycle.
module m_sram16_phasecnt
  import m_sram16_wbctrl_pkg::*;
#(
  parameter int unsigned WAITSTATES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(WAITSTATES);

  logic [CNT_W-1:0] cnt;

  generate
    if (WAITSTATES > MAX_WAITSTATES) begin : g_bad_waitstates
      $error("m_sram16_phasecnt: WAITSTATES must be 0..7");
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)               cnt <= '0;
    else if (run && !tc)   cnt <= cnt + 1'b1;
    else                   cnt <= '0;
  end

  assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/m_sram16_wbctrl.sv
// Wishbone-classic slave mapping 32-bit accesses onto a 16-bit async SRAM in
// two half-word phases with programmable wait states; all strobes are flops.
module m_sram16_wbctrl
  import m_sram16_wbctrl_pkg::*;
#(
  parameter int unsigned SRAMADRWIDTH = 16,
  parameter int unsigned WAITSTATES   = 1
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic                    CYC_I,
  input  logic                    STB_I,
  input  logic                    WE_I,
  input  logic [3:0]              SEL_I,
  input  logic [SRAMADRWIDTH:0]   ADR_I,
  input  logic [31:0]             DAT_I,
  output logic [31:0]             DAT_O,
  output logic                    ACK_O,
  output logic [SRAMADRWIDTH-1:0] SRAM_ADR,
  output logic [15:0]             SRAM_DAT_O,
  output logic                    SRAM_DAT_OE,
  input  logic [15:0]             SRAM_DAT_I,
  output logic                    SRAM_CSn,
  output logic                    SRAM_OEn,
  output logic                    SRAM_WEn,
  output logic                    SRAM_LBn,
  output logic                    SRAM_UBn
);

  state_t      state, state_nxt;
  logic        tc, run;
  logic [3:0]  sel_q;
  logic        we_q;
  logic [15:0] dat_hi_q;

  logic        accept;
  logic [3:0]  sel_eff;
  logic        we_eff;
  logic        in_lo, in_hi, in_phase;
  logic        cs_n_nxt, oe_n_nxt, we_n_nxt, lb_n_nxt, ub_n_nxt, dat_oe_nxt, ack_nxt;
  logic        capture_lo, capture_hi;

  logic unused_adr_lsbs;
  assign unused_adr_lsbs = &{1'b0, ADR_I[1:0]};

  assign run = ((state == S_LO) || (state == S_HI)) && CYC_I;

  m_sram16_phasecnt #(
    .WAITSTATES(WAITSTATES)
  ) u_phasecnt (
    .clk(CLK_I),
    .rst(RST_I),
    .run(run),
    .tc (tc)
  );

  always_ff @(posedge CLK_I) begin
    if (RST_I) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (CYC_I && STB_I) state_nxt = first_state(SEL_I);
      S_LO: begin
        if (!CYC_I)  state_nxt = S_IDLE;
        else if (tc) state_nxt = (|sel_q[3:2]) ? S_TURN : S_ACK;
      end
      S_TURN: state_nxt = CYC_I ? S_HI : S_IDLE;
      S_HI: begin
        if (!CYC_I)  state_nxt = S_IDLE;
        else if (tc) state_nxt = S_ACK;
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they leave flops aligned with state.
  always_comb begin
    accept     = (state == S_IDLE) && CYC_I && STB_I;
    sel_eff    = accept ? SEL_I : sel_q;
    we_eff     = accept ? WE_I : we_q;
    in_lo      = (state_nxt == S_LO);
    in_hi      = (state_nxt == S_HI);
    in_phase   = in_lo || in_hi;
    cs_n_nxt   = !in_phase;
    oe_n_nxt   = !(in_phase && !we_eff);
    we_n_nxt   = !(in_phase && we_eff);
    dat_oe_nxt = in_phase && we_eff;
    lb_n_nxt   = 1'b1;
    ub_n_nxt   = 1'b1;
    if (in_lo) begin
      lb_n_nxt = !sel_eff[0];
      ub_n_nxt = !sel_eff[1];
    end else if (in_hi) begin
      lb_n_nxt = !sel_eff[2];
      ub_n_nxt = !sel_eff[3];
    end
    ack_nxt    = (state_nxt == S_ACK);
    capture_lo = (state == S_LO) && tc && CYC_I && !we_q;
    capture_hi = (state == S_HI) && tc && CYC_I && !we_q;
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      ACK_O       <= 1'b0;
      DAT_O       <= '0;
      SRAM_ADR    <= '0;
      SRAM_DAT_O  <= '0;
      SRAM_DAT_OE <= 1'b0;
      SRAM_CSn    <= 1'b1;
      SRAM_OEn    <= 1'b1;
      SRAM_WEn    <= 1'b1;
      SRAM_LBn    <= 1'b1;
      SRAM_UBn    <= 1'b1;
      sel_q       <= '0;
      we_q        <= 1'b0;
      dat_hi_q    <= '0;
    end else begin
      ACK_O       <= ack_nxt;
      SRAM_DAT_OE <= dat_oe_nxt;
      SRAM_CSn    <= cs_n_nxt;
      SRAM_OEn    <= oe_n_nxt;
      SRAM_WEn    <= we_n_nxt;
      SRAM_LBn    <= lb_n_nxt;
      SRAM_UBn    <= ub_n_nxt;
      if (accept) begin
        sel_q    <= SEL_I;
        we_q     <= WE_I;
        dat_hi_q <= DAT_I[31:16];
        DAT_O    <= '0;
        if (state_nxt == S_LO) begin
          SRAM_ADR   <= {ADR_I[SRAMADRWIDTH:2], HALF_LO};
          SRAM_DAT_O <= DAT_I[15:0];
        end else if (state_nxt == S_HI) begin
          SRAM_ADR   <= {ADR_I[SRAMADRWIDTH:2], HALF_HI};
          SRAM_DAT_O <= DAT_I[31:16];
        end
      end
      if ((state == S_LO) && (state_nxt == S_TURN)) begin
        SRAM_ADR[0] <= HALF_HI;
        SRAM_DAT_O  <= dat_hi_q;
      end
      if (capture_lo) DAT_O[15:0]  <= SRAM_DAT_I;
      if (capture_hi) DAT_O[31:16] <= SRAM_DAT_I;
    end
  end

endmodule

// File: tb/tb_m_sram16_wbctrl.sv
// Directed bench: two controllers (WAITSTATES=1 and 0), each with its own
// behavioural 16-bit SRAM; one master drives whichever is selected by act.
module tb_m_sram16_wbctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [8:0]  adr = '0;
  logic [31:0] dat = '0;
  logic        act = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  logic [31:0] dato0, dato1;
  logic        ack0, ack1;
  logic [7:0]  sadr0, sadr1;
  logic [15:0] sdo0, sdo1, sdi0, sdi1;
  logic        soe0, soe1, csn0, csn1, oen0, oen1, wen0, wen1;
  logic        lbn0, lbn1, ubn0, ubn1;
  logic        cyc0, cyc1, stb0, stb1;

  logic [15:0] mem0 [256] = '{default: '0};
  logic [15:0] mem1 [256] = '{default: '0};

  assign cyc0 = cyc & ~act;
  assign stb0 = stb & ~act;
  assign cyc1 = cyc & act;
  assign stb1 = stb & act;

  assign sdi0 = (!csn0 && !oen0) ? mem0[sadr0] : 16'hxxxx;
  assign sdi1 = (!csn1 && !oen1) ? mem1[sadr1] : 16'hxxxx;

  m_sram16_wbctrl #(.SRAMADRWIDTH(8), .WAITSTATES(1)) u_dut0 (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc0), .STB_I(stb0), .WE_I(we),
    .SEL_I(sel), .ADR_I(adr), .DAT_I(dat), .DAT_O(dato0), .ACK_O(ack0),
    .SRAM_ADR(sadr0), .SRAM_DAT_O(sdo0), .SRAM_DAT_OE(soe0), .SRAM_DAT_I(sdi0),
    .SRAM_CSn(csn0), .SRAM_OEn(oen0), .SRAM_WEn(wen0), .SRAM_LBn(lbn0), .SRAM_UBn(ubn0)
  );

  m_sram16_wbctrl #(.SRAMADRWIDTH(8), .WAITSTATES(0)) u_dut1 (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc1), .STB_I(stb1), .WE_I(we),
    .SEL_I(sel), .ADR_I(adr), .DAT_I(dat), .DAT_O(dato1), .ACK_O(ack1),
    .SRAM_ADR(sadr1), .SRAM_DAT_O(sdo1), .SRAM_DAT_OE(soe1), .SRAM_DAT_I(sdi1),
    .SRAM_CSn(csn1), .SRAM_OEn(oen1), .SRAM_WEn(wen1), .SRAM_LBn(lbn1), .SRAM_UBn(ubn1)
  );

  always @(posedge clk) begin
    if (!csn0 && !wen0) begin
      if (!lbn0) mem0[sadr0][7:0]  <= sdo0[7:0];
      if (!ubn0) mem0[sadr0][15:8] <= sdo0[15:8];
    end
    if (!csn1 && !wen1) begin
      if (!lbn1) mem1[sadr1][7:0]  <= sdo1[7:0];
      if (!ubn1) mem1[sadr1][15:8] <= sdo1[15:8];
    end
  end

  logic        ack_a, csn_a, oen_a, wen_a, lbn_a, ubn_a;
  logic [31:0] dato_a;
  logic [7:0]  sadr_a;
  assign ack_a  = act ? ack1  : ack0;
  assign csn_a  = act ? csn1  : csn0;
  assign oen_a  = act ? oen1  : oen0;
  assign wen_a  = act ? wen1  : wen0;
  assign lbn_a  = act ? lbn1  : lbn0;
  assign ubn_a  = act ? ubn1  : ubn0;
  assign dato_a = act ? dato1 : dato0;
  assign sadr_a = act ? sadr1 : sadr0;

  int         csn_tot = 0, oen_tot = 0, wen_tot = 0, adr_viol = 0;
  logic       last_lbn = 1'b1, last_ubn = 1'b1, prev_wen = 1'b1;
  logic [7:0] last_adr = '0, prev_adr = '0;

  always @(negedge clk) begin
    if (csn_a === 1'b0) begin
      csn_tot  <= csn_tot + 1;
      last_lbn <= lbn_a;
      last_ubn <= ubn_a;
      last_adr <= sadr_a;
    end
    if (csn_a === 1'b0 && oen_a === 1'b0) oen_tot <= oen_tot + 1;
    if (csn_a === 1'b0 && wen_a === 1'b0) wen_tot <= wen_tot + 1;
    if (prev_wen === 1'b0 && wen_a === 1'b0 && prev_adr !== sadr_a) adr_viol <= adr_viol + 1;
    prev_wen <= wen_a;
    prev_adr <= sadr_a;
  end

  // Runs one request; n is the cycle ACK_O is seen in (request cycle = 1), -1 on timeout.
  task automatic do_req(input logic w, input logic [3:0] s, input logic [8:0] a,
                        input logic [31:0] d, output int n, output logic [31:0] rd);
    n  = -1;
    rd = 'x;
    @(posedge clk); #1;
    we = w; sel = s; adr = a; dat = d; cyc = 1'b1; stb = 1'b1;
    for (int i = 2; i < 40; i++) begin
      @(posedge clk); #1;
      if (ack_a === 1'b1) begin
        n  = i;
        rd = dato_a;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", ack0); end
    checks++; if (dato0 !== 32'h0) begin errors++; $display("FAIL reset_dat_o got %h want 0", dato0); end
    checks++; if ({csn0, oen0, wen0, lbn0, ubn0} !== 5'b11111) begin
      errors++; $display("FAIL reset_strobes got %b want 11111", {csn0, oen0, wen0, lbn0, ubn0}); end
    checks++; if (soe0 !== 1'b0) begin errors++; $display("FAIL reset_dat_oe got %b want 0", soe0); end
    checks++; if (sadr0 !== 8'h00) begin errors++; $display("FAIL reset_adr got %h want 00", sadr0); end
    checks++; if ({ack1, csn1, wen1, soe1} !== 4'b0110) begin
      errors++; $display("FAIL reset_dut_w0 got %b want 0110", {ack1, csn1, wen1, soe1}); end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    int acks;
    @(posedge clk); #1;
    we = 1'b1; sel = 4'hF; adr = 9'h010; dat = 32'hCAFEF00D; cyc = 1'b1; stb = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if ({sadr0, wen0} !== {8'h09, 1'b0}) begin
      errors++; $display("FAIL midhi_setup got adr=%h wen=%b want adr=09 wen=0", sadr0, wen0); end
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if ({wen0, csn0, soe0, ack0} !== 4'b1100) begin
      errors++; $display("FAIL midhi_reset got wen,csn,oe,ack=%b want 1100", {wen0, csn0, soe0, ack0}); end
    acks = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ack0 !== 1'b0) acks++;
    end
    checks++; if (acks != 0) begin errors++; $display("FAIL midhi_no_ack got %0d acks want 0", acks); end
  endtask

  task automatic test_write_word();
    int n, c0, w0, o0;
    logic [31:0] rd;
    c0 = csn_tot; w0 = wen_tot; o0 = oen_tot;
    do_req(1'b1, 4'hF, 9'h010, 32'hDEADBEEF, n, rd);
    checks++; if (n != 7) begin errors++; $display("FAIL wr_latency got %0d want 7", n); end
    checks++; if (mem0[8] !== 16'hBEEF) begin errors++; $display("FAIL wr_half8 got %h want beef", mem0[8]); end
    checks++; if (mem0[9] !== 16'hDEAD) begin errors++; $display("FAIL wr_half9 got %h want dead", mem0[9]); end
    checks++; if (wen_tot - w0 != 4) begin errors++; $display("FAIL wr_wen_cycles got %0d want 4", wen_tot - w0); end
    checks++; if (oen_tot - o0 != 0 || csn_tot - c0 != 4) begin
      errors++; $display("FAIL wr_oen_csn got oen=%0d csn=%0d want 0 4", oen_tot - o0, csn_tot - c0); end
  endtask

  task automatic test_read_word();
    int n, w0, o0;
    logic [31:0] rd;
    w0 = wen_tot; o0 = oen_tot;
    do_req(1'b0, 4'hF, 9'h010, 32'h0, n, rd);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", rd); end
    checks++; if (n != 7) begin errors++; $display("FAIL rd_latency got %0d want 7", n); end
    checks++; if (oen_tot - o0 != 4) begin errors++; $display("FAIL rd_oen_cycles got %0d want 4", oen_tot - o0); end
    checks++; if (wen_tot - w0 != 0) begin errors++; $display("FAIL rd_wen_cycles got %0d want 0", wen_tot - w0); end
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL rd_ack_one_cycle got %b want 0", ack0); end
  endtask

  task automatic test_byte_write();
    int n, c0;
    logic [31:0] rd;
    c0 = csn_tot;
    do_req(1'b1, 4'b0100, 9'h010, 32'h005A0000, n, rd);
    checks++; if (csn_tot - c0 != 2) begin errors++; $display("FAIL byte_csn_cycles got %0d want 2", csn_tot - c0); end
    checks++; if ({last_ubn, last_lbn} !== 2'b10) begin
      errors++; $display("FAIL byte_lanes got ub,lb=%b want 10", {last_ubn, last_lbn}); end
    checks++; if (last_adr !== 8'h09) begin errors++; $display("FAIL byte_adr got %h want 09", last_adr); end
    do_req(1'b0, 4'hF, 9'h010, 32'h0, n, rd);
    checks++; if (rd !== 32'hDE5ABEEF) begin errors++; $display("FAIL byte_readback got %h want de5abeef", rd); end
  endtask

  task automatic test_sel_zero();
    int n, c0;
    logic [31:0] rd;
    c0 = csn_tot;
    do_req(1'b0, 4'h0, 9'h010, 32'h0, n, rd);
    checks++; if (n != 2) begin errors++; $display("FAIL sel0_latency got %0d want 2", n); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sel0_data got %h want 0", rd); end
    checks++; if (csn_tot - c0 != 0) begin errors++; $display("FAIL sel0_csn got %0d want 0", csn_tot - c0); end
  endtask

  task automatic test_abort_turn();
    int acks, c0;
    c0 = csn_tot;
    @(posedge clk); #1;
    we = 1'b1; sel = 4'hF; adr = 9'h020; dat = 32'h12345678; cyc = 1'b1; stb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0;
    acks = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ack0 !== 1'b0) acks++;
    end
    checks++; if (acks != 0) begin errors++; $display("FAIL abort_no_ack got %0d acks want 0", acks); end
    checks++; if (csn_tot - c0 != 2) begin errors++; $display("FAIL abort_csn got %0d want 2", csn_tot - c0); end
    checks++; if (mem0[16] !== 16'h5678) begin errors++; $display("FAIL abort_half16 got %h want 5678", mem0[16]); end
    checks++; if (mem0[17] !== 16'h0000) begin errors++; $display("FAIL abort_half17 got %h want 0000", mem0[17]); end
  endtask

  task automatic test_waitstates0();
    int n, o0;
    logic [31:0] rd;
    act = 1'b1;
    do_req(1'b1, 4'hF, 9'h010, 32'hDEADBEEF, n, rd);
    checks++; if (n != 5) begin errors++; $display("FAIL w0_wr_latency got %0d want 5", n); end
    checks++; if ({mem1[9], mem1[8]} !== 32'hDEADBEEF) begin
      errors++; $display("FAIL w0_wr_mem got %h want deadbeef", {mem1[9], mem1[8]}); end
    o0 = oen_tot;
    do_req(1'b0, 4'hF, 9'h010, 32'h0, n, rd);
    checks++; if (n != 5) begin errors++; $display("FAIL w0_rd_latency got %0d want 5", n); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL w0_rd_data got %h want deadbeef", rd); end
    checks++; if (oen_tot - o0 != 2) begin errors++; $display("FAIL w0_oen_cycles got %0d want 2", oen_tot - o0); end
    act = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_reset_mid_write();
    test_write_word();
    test_read_word();
    test_byte_write();
    test_sel_zero();
    test_abort_turn();
    test_waitstates0();
    checks++; if (adr_viol != 0) begin errors++; $display("FAIL adr_stable_under_we got %0d changes want 0", adr_viol); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
